// File: rtl/div_unit_pkg.sv
// Shared state codes and handshake constants for the execute-stage divider.
// The values match the codes the execute stage already compares against.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [5:0] DivSteps = 6'd32;

  // Two's-complement magnitude of a 32-bit operand when it is treated as signed.
  function automatic logic [31:0] abs_operand(input logic is_signed, input logic [31:0] value);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring radix-2 divider for DIV/DIVU.
// Returns {remainder, quotient} with a registered ready pulse on the start/ready handshake.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] divisor;
  logic        neg_quo;
  logic        neg_rem;

  logic [65:0] shifted;
  logic [33:0] trial;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        abort;

  always_comb begin
    shifted = {work, 1'b0};
    // Upper part is below 2*divisor, so a 34-bit subtract gives a reliable sign bit.
    trial   = shifted[65:32] - {2'b00, divisor};
    quo_fix = neg_quo ? (~work[31:0] + 32'd1) : work[31:0];
    rem_fix = neg_rem ? (~work[63:32] + 32'd1) : work[63:32];
    abort   = annul_i || (start_i == DivStop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= DivFree;
      cnt      <= 6'd0;
      work     <= 65'd0;
      divisor  <= 32'd0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= 64'd0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= DivByZero;
            end else begin
              state   <= DivOn;
              cnt     <= 6'd0;
              work    <= {33'd0, abs_operand(signed_div_i, opdata1_i)};
              divisor <= abs_operand(signed_div_i, opdata2_i);
              neg_quo <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem <= signed_div_i && opdata1_i[31];
            end
          end
        end

        DivByZero: begin
          if (abort) begin
            state <= DivFree;
          end else begin
            state    <= DivEnd;
            result_o <= 64'd0;
          end
        end

        DivOn: begin
          if (abort) begin
            state <= DivFree;
          end else if (cnt == DivSteps) begin
            state    <= DivEnd;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= DivResultReady;
          end else begin
            work <= trial[33] ? shifted[64:0] : {trial[32:0], shifted[31:1], 1'b1};
            cnt  <= cnt + 6'd1;
          end
        end

        DivEnd: begin
          if (abort) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= 64'd0;
          end else begin
            ready_o <= DivResultReady;
          end
        end

        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, aborts, resets and
// randomized operands checked against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int tests_run = 0;
  int tests_failed = 0;

  div_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // DIV/DIVU semantics: truncating quotient, remainder takes the dividend's sign.
  function automatic logic [63:0] model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Raises start with the operands, then counts edges (acceptance edge = 1) until ready.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int edges, output bit done);
    @(negedge clk);
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    edges = 0;
    done = 1'b0;
    while (edges < 60 && !done) begin
      @(posedge clk);
      edges++;
      #1;
      if (ready) done = 1'b1;
      if (edges == 1) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~signed_div;
      end
    end
    res = result;
  endtask

  // Holds start two more edges, then drops it and samples after the next edge.
  task automatic release_start(output logic held_ready, output logic [63:0] held_res,
                               output logic after_ready, output logic [63:0] after_res);
    repeat (2) @(posedge clk);
    #1;
    held_ready = ready;
    held_res = result;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    after_ready = ready;
    after_res = result;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b want 0", ready);
    end
    tests_run++;
    if (result !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result: got %h want 0", result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    logic        vs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] va[5]  = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb[5]  = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1};
    logic [63:0] ve[5]  = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                            64'h00000001_FFFFFFFD, 64'h00000000_80000000,
                            64'h00000000_FFFFFFFF};
    logic [63:0] res, held_res, after_res;
    logic held_ready, after_ready;
    int edges;
    bit done;
    for (int i = 0; i < 5; i++) begin
      run_div(vs[i], va[i], vb[i], res, edges, done);
      tests_run++;
      if (!done || edges != 34) begin
        tests_failed++;
        $display("[TB] FAIL directed_latency[%0d]: got done=%0d edges=%0d want edges=34", i, done, edges);
      end
      tests_run++;
      if (res !== ve[i]) begin
        tests_failed++;
        $display("[TB] FAIL directed_result[%0d]: got %h want %h", i, res, ve[i]);
      end
      release_start(held_ready, held_res, after_ready, after_res);
      tests_run++;
      if (held_ready !== 1'b1 || held_res !== ve[i]) begin
        tests_failed++;
        $display("[TB] FAIL directed_hold[%0d]: got ready=%b res=%h want ready=1 res=%h", i, held_ready, held_res, ve[i]);
      end
      tests_run++;
      if (after_ready !== 1'b0 || after_res !== 64'd0) begin
        tests_failed++;
        $display("[TB] FAIL directed_drop[%0d]: got ready=%b res=%h want ready=0 res=0", i, after_ready, after_res);
      end
    end
  endtask

  task automatic test_by_zero();
    logic [63:0] res, held_res, after_res;
    logic held_ready, after_ready;
    int edges;
    bit done;
    for (int m = 0; m < 2; m++) begin
      run_div(m[0], $urandom, 32'd0, res, edges, done);
      tests_run++;
      if (!done || edges != 3) begin
        tests_failed++;
        $display("[TB] FAIL byzero_latency[%0d]: got done=%0d edges=%0d want edges=3", m, done, edges);
      end
      tests_run++;
      if (res !== 64'd0) begin
        tests_failed++;
        $display("[TB] FAIL byzero_result[%0d]: got %h want 0", m, res);
      end
      release_start(held_ready, held_res, after_ready, after_res);
      tests_run++;
      if (after_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL byzero_drop[%0d]: got ready=%b want 0", m, after_ready);
      end
    end
  endtask

  task automatic test_annul();
    logic [63:0] res, held_res, after_res;
    logic held_ready, after_ready;
    int edges;
    bit done;
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    tests_run++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL annul_output: got ready=%b res=%h want ready=0 res=0", ready, result);
    end
    run_div(1'b0, 32'd9, 32'd3, res, edges, done);
    tests_run++;
    if (!done || edges != 34) begin
      tests_failed++;
      $display("[TB] FAIL annul_next_latency: got done=%0d edges=%0d want edges=34", done, edges);
    end
    tests_run++;
    if (res !== 64'h00000000_00000003) begin
      tests_failed++;
      $display("[TB] FAIL annul_next_result: got %h want 0000000000000003", res);
    end
    release_start(held_ready, held_res, after_ready, after_res);
  endtask

  task automatic test_start_drop();
    bit seen_ready = 1'b0;
    @(negedge clk);
    signed_div = 1'b1;
    op1 = 32'hFFFF_FF00;
    op2 = 32'd5;
    start = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen_ready = 1'b1;
    end
    tests_run++;
    if (seen_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL start_drop_abort: got ready seen=%0d want 0", seen_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res, held_res, after_res;
    logic held_ready, after_ready;
    int edges;
    bit done;
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (21) @(posedge clk);
    #3;
    resetn = 1'b0;
    start = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_op: got ready=%b res=%h want ready=0 res=0", ready, result);
    end
    @(negedge clk);
    resetn = 1'b1;

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, edges, done);
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("[TB] FAIL reset_end_setup: got done=0 want 1");
    end
    #2;
    resetn = 1'b0;
    start = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_end: got ready=%b res=%h want ready=0 res=0", ready, result);
    end
    @(negedge clk);
    resetn = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, res, edges, done);
    tests_run++;
    if (!done || edges != 34 || res !== 64'h00000002_0000000E) begin
      tests_failed++;
      $display("[TB] FAIL reset_recover: got done=%0d edges=%0d res=%h want edges=34 res=000000020000000e", done, edges, res);
    end
    release_start(held_ready, held_res, after_ready, after_res);
  endtask

  task automatic test_random();
    logic [63:0] res, exp_res, held_res, after_res;
    logic held_ready, after_ready;
    logic s;
    logic [31:0] a, b;
    int edges, exp_edges;
    bit done;
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = ~($urandom_range(0, 14));
        4:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      exp_res = model_div(s, a, b);
      exp_edges = (b == 32'd0) ? 3 : 34;
      run_div(s, a, b, res, edges, done);
      tests_run++;
      if (!done || edges != exp_edges) begin
        tests_failed++;
        $display("[TB] FAIL random_latency[%0d]: got done=%0d edges=%0d want edges=%0d", i, done, edges, exp_edges);
      end
      tests_run++;
      if (res !== exp_res) begin
        tests_failed++;
        $display("[TB] FAIL random_result[%0d]: s=%0d a=%h b=%h got %h want %h", i, s, a, b, res, exp_res);
      end
      release_start(held_ready, held_res, after_ready, after_res);
      tests_run++;
      if (held_res !== exp_res || after_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL random_handshake[%0d]: got held=%h ready_after=%b want held=%h ready_after=0", i, held_res, after_ready, exp_res);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res, exp_res;
    logic s;
    logic [31:0] a, b;
    int edges;
    bit done;
    for (int i = 0; i < 4; i++) begin
      s = i[0];
      a = $urandom;
      b = $urandom_range(1, 1000);
      exp_res = model_div(s, a, b);
      run_div(s, a, b, res, edges, done);
      tests_run++;
      if (!done || edges != 34 || res !== exp_res) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back[%0d]: got done=%0d edges=%0d res=%h want edges=34 res=%h", i, done, edges, res, exp_res);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
  endtask

  initial begin
    resetn = 1'b0;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    start = 1'b0;
    annul = 1'b0;
    test_reset();
    test_directed();
    test_by_zero();
    test_annul();
    test_start_drop();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 divider serving the execute stage's DIV/DIVU instructions. It is the responder side of the stage's start/ready divide handshake: it accepts operands on `start_i`, runs one quotient bit per cycle, and returns `{remainder, quotient}` for the HI/LO write with a `ready_o` pulse. It sits beside the multiplier inside the execute stage and holds no pipeline state of its own.

## Interface
- No parameters; operand width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at acceptance.
- `opdata1_i`  in  32  dividend; sampled at acceptance.
- `opdata2_i`  in  32  divisor; sampled at acceptance.
- `start_i`  in  1  request; held high by the initiator until it sees `ready_o`.
- `annul_i`  in  1  abort the current operation.
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`; upper half goes to HI, lower half to LO. Reset 0.
- `ready_o`  out  1  result valid. Registered. Reset 0.

## Operation
- States: FREE, BYZERO, ON, END, encoded in 2 bits.
- **FREE**
  - `start_i=1`, `annul_i=0`, divisor ≠ 0: latch |dividend|, |divisor| and the sign flags, clear the 6-bit count, go to ON.
  - Divisor = 0: go to BYZERO.
  - Otherwise stay in FREE with `ready_o=0` and `result_o=0`.
- **BYZERO**
  - Next edge: go to END with result 0.
- **ON** (one restoring shift-subtract step per cycle on a 65-bit working register `{rem[32:0], quo[31:0]}`)
  - Shift left by 1.
  - 33-bit trial subtract of the divisor from the upper part.
  - If the result is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore.
  - When count reaches 32, go to END.
- **END**
  - Entry: in signed mode, negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
  - Drive `result_o` and `ready_o=1`.
  - Stay while `start_i=1`.
  - `start_i=0`: go to FREE; `ready_o` and `result_o` return to 0.
- Abort: `annul_i=1` or `start_i=0` in BYZERO or ON sends the block to FREE on the next edge with no result. This covers pipeline flushes that zero the EX bus.
- Operand changes after acceptance are ignored.
- Overflow case −2^31 / −1 (signed) yields quotient 0x80000000 and remainder 0 through two's-complement wrap. It is not flagged.
- Divide by zero yields `result_o = 0`. Architecturally the result is UNPREDICTABLE; 0 is the fixed choice.

## Timing
- Acceptance edge T (FREE with `start_i` high).
- Normal path:
  - ON from T through T+32.
  - END and `ready_o=1` visible after edge T+33.
  - The initiator therefore stalls 33 cycles.
- Divide by zero: `ready_o=1` after edge T+2.
- `ready_o` stays high until the first edge with `start_i=0`, then drops on that edge.
- A new `start_i` is accepted no earlier than the edge after returning to FREE.
- `annul_i` has priority over every other condition in every state except FREE.
- Annul/start-drop and count==32 on the same edge: abort wins.
- `resetn` low at any time, including mid-operation:
  - Immediately FREE, `ready_o=0`, `result_o=0`, count 0.
  - Working registers are cleared asynchronously.

## Structure
- Shared constants belong in `lib/defines.vh`:
  - DivFree/DivByZero/DivOn/DivEnd state codes.
  - DivStart/DivStop.
  - DivResultReady/DivResultNotReady.
- Single module; no sub-module. The 33-bit subtractor and the negations are inline.
- The shared constants must match the values the execute stage already compares against.

## Test plan
- Unsigned 100 / 7 → after 33 cycles `ready_o=1`, `result_o = 0x00000002_0000000E`; drop `start_i` → `ready_o=0` the next cycle.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → `result_o = 0xFFFFFFFF_FFFFFFFD`. Signed 7 / −2 → `0x00000001_FFFFFFFD`.
- Signed 0x80000000 / 0xFFFFFFFF → `result_o = 0x00000000_80000000`. Unsigned 0xFFFFFFFF / 1 → `0x00000000_FFFFFFFF`.
- Divisor 0 (either mode) → `ready_o=1` two cycles after acceptance, `result_o = 0`.
- `annul_i` pulsed at iteration 10 → FREE next cycle, `ready_o` never rises. An immediately following unsigned 9 / 3 returns `0x00000000_00000003` at T+33.
- `resetn` asserted low at iteration 20 → `ready_o=0` and `result_o=0` with no clock edge. After release, a fresh 100 / 7 completes normally.
